mult_div_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 36 +++
 rtl/md_calc.sv | 61 ++++++
 rtl/mult_div_unit.sv | 103 ++++++++++
 tb/tb_mult_div_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and its EX-stage wiring.
//   md_op_e      : operation select driven by the decoder into mult_div_unit
//   hilo_class_e : decoder HI/LO instruction class (01 hi, 10 lo, 11 mul/div)
//   *_CYCLES_DEF : default busy durations
package mdu_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MADD  = 3'd4,
      MD_MADDU = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      HL_NONE = 2'b00,
      HL_HI   = 2'b01,
      HL_LO   = 2'b10,
      HL_MD   = 2'b11
   } hilo_class_e;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;
   localparam int unsigned CNT_W           = 4;

   // Encodings 6 and 7 are reserved and must not start an operation.
   function automatic logic md_op_legal(input logic [2:0] op);
      return (op <= 3'd5);
   endfunction

   function automatic logic md_op_is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational result generator for mult/multu/div/divu/madd/maddu.
//   i_md_op    : operation select (md_op_e encoding)
//   i_rs/i_rt  : operands (dividend/multiplicand, divisor/multiplier)
//   i_hilo     : current committed {HI,LO}, used as madd accumulator
//   o_result   : next {HI,LO}
//   o_div_zero : div/divu with a zero divisor
module md_calc
   import mdu_pkg::*;
(
   input  logic [2:0]  i_md_op,
   input  logic [31:0] i_rs,
   input  logic [31:0] i_rt,
   input  logic [63:0] i_hilo,
   output logic [63:0] o_result,
   output logic        o_div_zero
);

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic        w_sdiv;
   logic [31:0] w_dvd;
   logic [31:0] w_dvs;
   logic [31:0] w_dvs_safe;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

   // Sign-extending to 64 bits gives the exact signed product modulo 2^64.
   assign w_prod_s = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
   assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

   // One unsigned divider serves both div and divu: signed division runs on
   // magnitudes and fixes the signs afterwards. 0x80000000 / -1 falls out
   // naturally as magnitude 0x80000000 with a positive sign.
   assign w_sdiv     = (i_md_op == MD_DIV);
   assign w_dvd      = (w_sdiv && i_rs[31]) ? (~i_rs + 32'd1) : i_rs;
   assign w_dvs      = (w_sdiv && i_rt[31]) ? (~i_rt + 32'd1) : i_rt;
   assign w_dvs_safe = (w_dvs == '0) ? 32'd1 : w_dvs;
   assign w_q_mag    = w_dvd / w_dvs_safe;
   assign w_r_mag    = w_dvd % w_dvs_safe;
   assign w_quo      = (w_sdiv && (i_rs[31] ^ i_rt[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
   assign w_rem      = (w_sdiv && i_rs[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

   always_comb begin
      o_result   = i_hilo;
      o_div_zero = 1'b0;
      case (i_md_op)
         MD_MULT:  o_result = w_prod_s;
         MD_MULTU: o_result = w_prod_u;
         MD_DIV, MD_DIVU: begin
            o_div_zero = (i_rt == '0);
            o_result   = {w_rem, w_quo};
         end
         MD_MADD:  o_result = i_hilo + w_prod_s;
         MD_MADDU: o_result = i_hilo + w_prod_u;
         default:  o_result = i_hilo;
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
//   clk, reset        : clock, synchronous active-high reset
//   start, md_op      : mult/div/madd issue and operation select
//   hi_we, lo_we      : mthi/mtlo writes of rs_data
//   rs_data, rt_data  : forwarded operands
//   hi, lo            : committed HI/LO
//   busy              : operation in flight (fixed latency per op class)
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy
);

   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   state_e           r_state, w_state_n;
   logic [CNT_W-1:0] r_cnt, w_cnt_n;
   logic [31:0]      r_p_hi, r_p_lo, w_p_hi_n, w_p_lo_n;
   logic [31:0]      r_hi, r_lo, w_hi_n, w_lo_n;
   logic [63:0]      w_calc;
   logic             w_div_zero;

   md_calc u_calc (
      .i_md_op    (md_op),
      .i_rs       (rs_data),
      .i_rt       (rt_data),
      .i_hilo     ({r_hi, r_lo}),
      .o_result   (w_calc),
      .o_div_zero (w_div_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_p_hi  <= '0;
         r_p_lo  <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_p_hi  <= w_p_hi_n;
         r_p_lo  <= w_p_lo_n;
         r_hi    <= w_hi_n;
         r_lo    <= w_lo_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_p_hi_n  = r_p_hi;
      w_p_lo_n  = r_p_lo;
      w_hi_n    = r_hi;
      w_lo_n    = r_lo;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               // start suppresses mthi/mtlo even when md_op is reserved.
               if (md_op_legal(md_op)) begin
                  w_state_n = ST_RUN;
                  w_cnt_n   = md_op_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  // A zero divisor commits the current HI/LO back unchanged;
                  // HI/LO cannot move while RUN, so this equals "no write".
                  w_p_hi_n  = w_div_zero ? r_hi : w_calc[63:32];
                  w_p_lo_n  = w_div_zero ? r_lo : w_calc[31:0];
               end
            end else begin
               if (hi_we) w_hi_n = rs_data;
               if (lo_we) w_lo_n = rs_data;
            end
         end
         ST_RUN: begin
            w_cnt_n = r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               w_state_n = ST_IDLE;
               w_hi_n    = r_p_hi;
               w_lo_n    = r_p_lo;
            end
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign busy = (r_state == ST_RUN);

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected {HI,LO} values are pushed when
// an operation is issued and popped when busy falls.
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, hi_we, lo_we, busy;
   logic [2:0]  md_op;
   logic [31:0] rs_data, rt_data, hi, lo;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] sb_q[$];
   logic [31:0] m_hi, m_lo;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .md_op   (md_op),
      .hi_we   (hi_we),
      .lo_we   (lo_we),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .hi      (hi),
      .lo      (lo),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd0: return sa * sb;
         3'd1: return ua * ub;
         3'd2: begin
            if (b == 32'd0) return acc;
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'd3: begin
            if (b == 32'd0) return acc;
            return {32'(ua % ub), 32'(ua / ub)};
         end
         3'd4: return acc + sa * sb;
         3'd5: return acc + ua * ub;
         default: return acc;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] e;
      e = model(op, a, b, {m_hi, m_lo});
      sb_q.push_back(e);
      {m_hi, m_lo} = e;
      start   = 1'b1;
      md_op   = op;
      rs_data = a;
      rt_data = b;
      step();
      start = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; md_op = MD_MULT; hi_we = 1'b1; lo_we = 1'b1;
      rs_data = 32'hDEAD_BEEF; rt_data = 32'h1234_5678;
      step(); step();
      reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      m_hi = '0; m_lo = '0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
      total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
   endtask

   task automatic test_mult();
      int n;
      logic [63:0] e;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: issue(MD_MULT,  32'hFFFF_FFFF, 32'd2);
            1: issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
            default: issue(MD_MULT, 32'h8000_0000, 32'h8000_0000);
         endcase
         wait_idle(n);
         e = sb_q.pop_front();
         total++; if (n !== 5) begin bad++; $display("FAIL mult%0d_busy got=%0d want=5", i, n); end
         total++; if ({hi, lo} !== e) begin bad++; $display("FAIL mult%0d_hilo got=%h want=%h", i, {hi, lo}, e); end
      end
   endtask

   task automatic test_div();
      int n;
      logic [63:0] e;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: issue(MD_DIV,  32'hFFFF_FFF9, 32'd2);
            1: issue(MD_DIVU, 32'd7, 32'd0);
            default: issue(MD_DIV, 32'd100, 32'hFFFF_FFF9);
         endcase
         wait_idle(n);
         e = sb_q.pop_front();
         total++; if (n !== 10) begin bad++; $display("FAIL div%0d_busy got=%0d want=10", i, n); end
         total++; if ({hi, lo} !== e) begin bad++; $display("FAIL div%0d_hilo got=%h want=%h", i, {hi, lo}, e); end
      end
   endtask

   task automatic test_madd();
      int n;
      logic [63:0] e;
      hi_we = 1'b1; rs_data = 32'h0000_0001;
      step();
      hi_we = 1'b0; m_hi = 32'h0000_0001;
      total++; if (hi !== 32'h1) begin bad++; $display("FAIL mthi got=%h want=00000001", hi); end
      lo_we = 1'b1; rs_data = 32'hFFFF_FFFF;
      step();
      lo_we = 1'b0; m_lo = 32'hFFFF_FFFF;
      total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mtlo got=%h want=ffffffff", lo); end
      issue(MD_MADDU, 32'd1, 32'd1);
      wait_idle(n);
      e = sb_q.pop_front();
      total++; if (n !== 5) begin bad++; $display("FAIL maddu_busy got=%0d want=5", n); end
      total++; if ({hi, lo} !== e) begin bad++; $display("FAIL maddu_hilo got=%h want=%h", {hi, lo}, e); end
      issue(MD_MADD, 32'hFFFF_FFFF, 32'd3);
      wait_idle(n);
      e = sb_q.pop_front();
      total++; if ({hi, lo} !== e) begin bad++; $display("FAIL madd_hilo got=%h want=%h", {hi, lo}, e); end
   endtask

   task automatic test_ignore_midrun();
      int n;
      logic [63:0] e, prev;
      prev = {m_hi, m_lo};
      issue(MD_MULT, 32'h0001_2345, 32'h0000_1000);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         if (n == 2) begin
            start = 1'b1; md_op = MD_MULTU; hi_we = 1'b1; lo_we = 1'b1;
            rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF;
         end else begin
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
         end
         if (n == 3) begin
            total++;
            if ({hi, lo} !== prev) begin bad++; $display("FAIL midrun_pending_visible got=%h want=%h", {hi, lo}, prev); end
         end
         step();
      end
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      e = sb_q.pop_front();
      total++; if (n !== 5) begin bad++; $display("FAIL midrun_busy got=%0d want=5", n); end
      total++; if ({hi, lo} !== e) begin bad++; $display("FAIL midrun_hilo got=%h want=%h", {hi, lo}, e); end
   endtask

   task automatic test_precedence();
      int n;
      logic [63:0] e, prev;
      hi_we = 1'b1; lo_we = 1'b1;
      issue(MD_MULT, 32'd5, 32'd6);
      hi_we = 1'b0; lo_we = 1'b0;
      wait_idle(n);
      e = sb_q.pop_front();
      total++; if ({hi, lo} !== e) begin bad++; $display("FAIL start_wins_hilo got=%h want=%h", {hi, lo}, e); end
      prev = {m_hi, m_lo};
      start = 1'b1; md_op = 3'd6; rs_data = 32'd9; rt_data = 32'd9;
      step();
      start = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reserved_busy got=%b want=0", busy); end
      step();
      total++; if ({hi, lo} !== prev) begin bad++; $display("FAIL reserved_hilo got=%h want=%h", {hi, lo}, prev); end
   endtask

   task automatic test_back_to_back();
      int n;
      logic [63:0] e;
      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      e = sb_q.pop_front();
      total++; if (n !== 10) begin bad++; $display("FAIL b2b_div_busy got=%0d want=10", n); end
      total++; if ({hi, lo} !== e) begin bad++; $display("FAIL b2b_div_hilo got=%h want=%h", {hi, lo}, e); end
      issue(MD_MULT, 32'h8000_0000, 32'd3);
      wait_idle(n);
      e = sb_q.pop_front();
      total++; if (n !== 5) begin bad++; $display("FAIL b2b_mult_busy got=%0d want=5", n); end
      total++; if ({hi, lo} !== e) begin bad++; $display("FAIL b2b_mult_hilo got=%h want=%h", {hi, lo}, e); end
      issue(MD_MADD, 32'd2, 32'd2);
      wait_idle(n);
      e = sb_q.pop_front();
      total++; if ({hi, lo} !== e) begin bad++; $display("FAIL b2b_madd_hilo got=%h want=%h", {hi, lo}, e); end
   endtask

   task automatic test_reset_midrun();
      logic [63:0] e;
      issue(MD_DIV, 32'd1000, 32'd7);
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      e = sb_q.pop_front();
      m_hi = '0; m_lo = '0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
      total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL abort_hilo got=%h want=0 (discarded %h)", {hi, lo}, e); end
      for (int i = 0; i < 12; i++) step();
      total++; if ({busy, hi, lo} !== 65'd0) begin bad++; $display("FAIL abort_late_commit got=%h want=0", {busy, hi, lo}); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; md_op = '0; hi_we = 1'b0; lo_we = 1'b0;
      rs_data = '0; rt_data = '0; m_hi = '0; m_lo = '0;
      test_reset();
      test_mult();
      test_div();
      test_madd();
      test_ignore_midrun();
      test_precedence();
      test_back_to_back();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
